key_event_fifo: RTL and testbench

- Reader/consumer end of the 4x4 keypad scanner. Takes the scanner's 16-bit key bitmap, where 0 means pressed.
- Synchronizes and debounces the bitmap, detects press edges and encodes each press as a 4-bit key index.
- Queues events in a small FIFO with a valid/ready handshake, so the control FSM (temperature and mode setting) sees one event per keypress.

---
 rtl/key_event_fifo.sv | 197 +++++++++++++++++++
 tb/tb_key_event_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - keypad bitmap debouncer, press encoder and event FIFO
//
// Purpose:
//   Consumer end of the 4x4 keypad scanner. The active-low 16-bit key bitmap
//   is synchronized and debounced with one shared counter. Press edges
//   (1->0 on the debounced bitmap) are encoded lowest-index-first, one per
//   cycle, into a first-word-fall-through event FIFO with a valid/ready
//   handshake.
//
// Optional feature macro: RELEASE_EVENT_EN
//   Defined     : release edges (0->1) are also queued. Presses are served
//                 before releases. FIFO entries are {release, code}.
//   Not defined : presses only, key_release is tied low.
//
// Ports:
//   clkin       in   1        system clock
//   rst         in   1        synchronous active-high reset
//   keys        in   16       scanner bitmap, bit i low = key i pressed (async)
//   key_code    out  4        index of oldest queued event (0 when empty)
//   key_release out  1        event type of key_code (1 = release)
//   key_valid   out  1        FIFO non-empty
//   key_ready   in   1        consumer takes the head event
//   overflow    out  1        sticky: an event was dropped on a full FIFO
//   ovf_clr     in   1        clears overflow (set wins in the same cycle)
//   fifo_count  out  ADDR_W+1 number of queued events

module key_event_fifo #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int ADDR_W          = 2
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [15:0]       keys,
    output logic [3:0]        key_code,
    output logic              key_release,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [ADDR_W:0]   fifo_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);
`ifdef RELEASE_EVENT_EN
    localparam int ENTRY_W = 5;
`else
    localparam int ENTRY_W = 4;
`endif

    // Isolate the lowest set bit.
    function automatic logic [15:0] f_lowest(input logic [15:0] v);
        return v & (~v + 16'd1);
    endfunction

    // Index of the lowest set bit; scanning downwards lets the lowest win.
    function automatic logic [3:0] f_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [15:0]        r_s1;
    logic [15:0]        r_s2;
    logic [15:0]        r_prev;
    logic [15:0]        r_stable;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_pend;
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;

    logic               w_commit;
    logic [15:0]        w_next_stable;
    logic [15:0]        w_press_mask;
    logic [15:0]        w_pick_onehot;
    logic [15:0]        w_clr_press;
    logic               w_push;
    logic [ENTRY_W-1:0] w_push_data;
    logic               w_pop;
    logic               w_accept;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;

    // The debounced bitmap takes the synchronized value only after it has
    // been unchanged for DEBOUNCE_CYCLES cycles.
    assign w_commit      = (r_s2 == r_prev) && (r_cnt == CNT_LAST);
    assign w_next_stable = w_commit ? r_s2 : r_stable;
    assign w_press_mask  = r_stable & ~w_next_stable;

`ifdef RELEASE_EVENT_EN
    logic [15:0] r_pend_r;
    logic [15:0] w_release_mask;
    logic [15:0] w_pick_src;
    logic        w_serve_press;
    logic [15:0] w_clr_release;

    assign w_release_mask = ~r_stable & w_next_stable;
    // Presses are drained completely before any release is served.
    assign w_serve_press  = |r_pend;
    assign w_pick_src     = w_serve_press ? r_pend : r_pend_r;
    assign w_pick_onehot  = f_lowest(w_pick_src);
    assign w_clr_press    = w_serve_press ? w_pick_onehot : 16'd0;
    assign w_clr_release  = w_serve_press ? 16'd0 : w_pick_onehot;
    assign w_push         = (|r_pend) | (|r_pend_r);
    assign w_push_data    = {~w_serve_press, f_index(w_pick_src)};

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_pend_r <= 16'd0;
        end else begin
            r_pend_r <= (r_pend_r & ~w_clr_release) | w_release_mask;
        end
    end

    assign key_release = key_valid ? w_head[4] : 1'b0;
`else
    assign w_pick_onehot = f_lowest(r_pend);
    assign w_clr_press   = w_pick_onehot;
    assign w_push        = |r_pend;
    assign w_push_data   = f_index(r_pend);
    assign key_release   = 1'b0;
`endif

    // A push into a full FIFO survives only if the head leaves this cycle.
    assign w_pop    = key_valid & key_ready;
    assign w_accept = w_push & ((r_count != FULL_CNT) | w_pop);
    assign w_drop   = w_push & ~w_accept;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_s1       <= 16'hFFFF;
            r_s2       <= 16'hFFFF;
            r_prev     <= 16'hFFFF;
            r_stable   <= 16'hFFFF;
            r_cnt      <= '0;
            r_pend     <= 16'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_s1   <= keys;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            if (r_s2 != r_prev) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_stable <= w_next_stable;

            // New edges are ORed after the clear so a same-cycle pick of the
            // same bit cannot swallow a fresh edge.
            r_pend <= (r_pend & ~w_clr_press) | w_press_mask;

            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clkin) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign key_valid  = (r_count != '0);
    assign key_code   = key_valid ? w_head[3:0] : 4'd0;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_key_event_fifo.sv
// tb/tb_key_event_fifo.sv - self-checking bench for key_event_fifo
module tb_key_event_fifo;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic        clkin = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'hFFFF;
    logic [3:0]  key_code;
    logic        key_release;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int got[$];
    int exp_q[$];

    key_event_fifo #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(16),
        .FIFO_DEPTH(DEPTH),
        .ADDR_W(2)
    ) dut (
        .clkin(clkin),
        .rst(rst),
        .keys(keys),
        .key_code(key_code),
        .key_release(key_release),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .fifo_count(fifo_count)
    );

    always #5 clkin = ~clkin;

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop everything with key_ready high, recording {release, code}.
    task automatic drain(input int max_cycles);
        got.delete();
        key_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (key_valid) got.push_back({27'd0, key_release, key_code});
            tick(1);
        end
        key_ready = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic tap(input int idx, input int hold);
        keys = ~(16'd1 << idx);
        tick(hold);
        keys = 16'hFFFF;
        tick(hold);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_release", key_release, 0);

`ifdef RELEASE_EVENT_EN
        tick(20);
        tap(7, 20);
        exp_q = '{7, 16 + 7};
        drain(6);
        compare_q("release7");
`else
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (key_valid) seen_valid = 1'b1;
                tick(1);
            end
            check("idle_no_valid", seen_valid, 0);
        end

        // Single press of key 5, latency measured from the input change
        keys = 16'hFFDF;
        lat = 0;
        while (!key_valid && lat < 30) begin
            tick(1);
            lat++;
        end
        check("lat_window", (lat >= DEB + 4 && lat <= DEB + 6), 1);
        tick(50 - lat);
        check("hold_count", fifo_count, 1);
        check("hold_code", key_code, 5);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("pop_count", fifo_count, 0);
        check("pop_valid", key_valid, 0);
        keys = 16'hFFFF;
        tick(20);
        check("release_no_event", fifo_count, 0);

        // Bounce on key 3 then settle low
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'hFFF7 : 16'hFFFF;
            tick(2);
        end
        check("bounce_none", fifo_count, 0);
        keys = 16'hFFF7;
        tick(30);
        check("bounce_count", fifo_count, 1);
        exp_q = '{3};
        drain(4);
        compare_q("bounce");
        keys = 16'hFFFF;
        tick(20);
        keys = 16'hFFF7;
        tick(3);
        keys = 16'hFFFF;
        tick(30);
        check("glitch_none", fifo_count, 0);

        // Keys 0 and 15 together: pushed on consecutive cycles, 0 first
        keys = 16'h7FFE;
        lat = 0;
        while (!key_valid && lat < 30) begin
            tick(1);
            lat++;
        end
        check("simul_first_count", fifo_count, 1);
        check("simul_first_code", key_code, 0);
        tick(1);
        check("simul_second_count", fifo_count, 2);
        tick(10);
        exp_q = '{0, 15};
        drain(6);
        compare_q("simul");
        keys = 16'hFFFF;
        tick(20);

        // Random simultaneous press sets against an ordering/drop model
        for (int t = 0; t < 5; t++) begin
            logic [15:0] m;
            int k;
            k = $urandom_range(2, 7);
            m = 16'd0;
            while ($countones(m) < k) m[$urandom_range(0, 15)] = 1'b1;
            exp_q.delete();
            for (int i = 0; i < 16; i++)
                if (m[i] && exp_q.size() < DEPTH) exp_q.push_back(i);
            keys = ~m;
            tick(30);
            check($sformatf("rnd%0d_count", t), fifo_count, (k < DEPTH) ? k : DEPTH);
            check($sformatf("rnd%0d_ovf", t), overflow, (k > DEPTH) ? 1 : 0);
            drain(10);
            compare_q($sformatf("rnd%0d", t));
            keys = 16'hFFFF;
            tick(20);
            ovf_clr = 1'b1;
            tick(1);
            ovf_clr = 1'b0;
            check($sformatf("rnd%0d_clr", t), overflow, 0);
        end

        // Sequential overflow with keys 1,2,3,4,6
        tap(1, 15);
        tap(2, 15);
        tap(3, 15);
        tap(4, 15);
        check("full_no_ovf", overflow, 0);
        tap(6, 15);
        check("ovf_count", fifo_count, 4);
        check("ovf_set", overflow, 1);
        check("ovf_head", key_code, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // Full FIFO: pop lands on the same edge as key 10's push
        keys = ~(16'd1 << 10);
        tick(lat - 1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("pushpop_count", fifo_count, 4);
        check("pushpop_ovf", overflow, 0);
        check("pushpop_head", key_code, 2);
        tick(5);
        exp_q = '{2, 3, 4, 10};
        drain(8);
        compare_q("pushpop");
        keys = 16'hFFFF;
        tick(20);

        // Reset with events queued and key 9 held
        tap(1, 15);
        tap(2, 15);
        check("pre_rst_count", fifo_count, 2);
        keys = ~(16'd1 << 9);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_count", fifo_count, 0);
        check("midrst_valid", key_valid, 0);
        tick(30);
        check("post_rst_count", fifo_count, 1);
        exp_q = '{9};
        drain(4);
        compare_q("post_rst");
        keys = 16'hFFFF;
        tick(20);
        check("final_empty", fifo_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
